// File: rtl/race_pkg.sv
// Shared race-state encoding used by the game-flow FSM, physics engine and HUD.
package race_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] SETTING   = 3'd1;
  localparam logic [STATE_W-1:0] COUNTDOWN = 3'd3;
  localparam logic [STATE_W-1:0] RACING    = 3'd4;
  localparam logic [STATE_W-1:0] PAUSE     = 3'd5;
  localparam logic [STATE_W-1:0] FINISH    = 3'd6;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler.
//   clk, rst_n : clock, async active-low reset
//   enable     : count while high
//   freeze     : hold the current count (overrides enable)
//   clear      : force count to 0 (overrides everything)
//   sec_tick_c : combinational, high on the last cycle of each second
module sec_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic freeze,
  input  logic clear,
  output logic sec_tick_c
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             run;

  assign run        = enable && !freeze && !clear;
  assign sec_tick_c = run && (cnt_q == CNT_MAX);

  // Prescaler register: clear wins, then freeze, then count with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= sec_tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/race_state_fsm.sv
// Racing game-flow controller: IDLE -> SETTING -> COUNTDOWN -> RACING <-> PAUSE -> FINISH,
// with countdown seconds, elapsed race time and lap counting. All outputs registered.
//   clk, rst_n     : clock, async active-low reset
//   start_pulse    : start/confirm button pulse
//   pause_pulse    : pause toggle pulse
//   lap_pulse      : finish-line crossing pulse
//   state          : race state code (race_pkg encoding)
//   countdown      : seconds remaining, nonzero only in COUNTDOWN
//   lap_count      : completed laps
//   race_time_sec  : elapsed racing seconds, saturating at TIME_MAX
//   go_pulse       : first RACING cycle after COUNTDOWN
module race_state_fsm
  import race_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned COUNT_SECS    = 3,
  parameter int unsigned NUM_LAPS      = 3,
  parameter int unsigned TIME_MAX      = 999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_pulse,
  input  logic         pause_pulse,
  input  logic         lap_pulse,
  output logic [2:0]   state,
  output logic [3:0]   countdown,
  output logic [3:0]   lap_count,
  output logic [9:0]   race_time_sec,
  output logic         go_pulse
);

  localparam int unsigned CD_W  = 4;
  localparam int unsigned LAP_W = 4;
  localparam int unsigned TIM_W = 10;

  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COUNT_SECS);
  localparam logic [LAP_W-1:0] LAP_GOAL = LAP_W'(NUM_LAPS);
  localparam logic [LAP_W-1:0] LAP_SAT  = '1;
  localparam logic [TIM_W-1:0] TIM_SAT  = TIM_W'(TIME_MAX);

  logic [STATE_W-1:0] state_q;
  logic               sec_tick_c;
  logic               tick_en_c;
  logic               tick_freeze_c;
  logic               tick_clear_c;
  logic [LAP_W-1:0]   lap_inc_c;

  assign state = state_q;

  // Prescaler runs in COUNTDOWN/RACING, holds in PAUSE, is cleared everywhere else.
  assign tick_en_c     = (state_q == COUNTDOWN) || (state_q == RACING);
  assign tick_freeze_c = (state_q == PAUSE);
  assign tick_clear_c  = !(tick_en_c || tick_freeze_c);

  assign lap_inc_c = (lap_count == LAP_SAT) ? lap_count : lap_count + LAP_W'(1);

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (tick_en_c),
    .freeze     (tick_freeze_c),
    .clear      (tick_clear_c),
    .sec_tick_c (sec_tick_c)
  );

  // State machine and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      countdown     <= '0;
      lap_count     <= '0;
      race_time_sec <= '0;
      go_pulse      <= 1'b0;
    end else begin
      go_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_pulse) state_q <= SETTING;
        end
        SETTING: begin
          if (start_pulse) begin
            state_q   <= COUNTDOWN;
            countdown <= CD_LOAD;
          end
        end
        COUNTDOWN: begin
          if (sec_tick_c) begin
            if (countdown > CD_W'(1)) begin
              countdown <= countdown - CD_W'(1);
            end else begin
              state_q   <= RACING;
              countdown <= '0;
              go_pulse  <= 1'b1;
            end
          end
        end
        RACING: begin
          if (sec_tick_c && (race_time_sec != TIM_SAT)) begin
            race_time_sec <= race_time_sec + TIM_W'(1);
          end
          // A lap in the same cycle as pause is counted first; finishing wins over pausing.
          if (lap_pulse) begin
            lap_count <= lap_inc_c;
            if (lap_inc_c == LAP_GOAL) state_q <= FINISH;
            else if (pause_pulse)      state_q <= PAUSE;
          end else if (pause_pulse) begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_pulse) state_q <= RACING;
        end
        FINISH: begin
          if (start_pulse) begin
            state_q       <= IDLE;
            countdown     <= '0;
            lap_count     <= '0;
            race_time_sec <= '0;
          end
        end
        default: begin
          state_q       <= IDLE;
          countdown     <= '0;
          lap_count     <= '0;
          race_time_sec <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_state_fsm.sv
// Directed bench for race_state_fsm with TICKS_PER_SEC=4, COUNT_SECS=3, NUM_LAPS=2.
module tb_race_state_fsm;

  logic       clk;
  logic       rst_n;
  logic       start_pulse;
  logic       pause_pulse;
  logic       lap_pulse;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [3:0] lap_count;
  logic [9:0] race_time_sec;
  logic       go_pulse;

  int n_checks = 0;
  int n_fails  = 0;

  race_state_fsm #(
    .TICKS_PER_SEC (4),
    .COUNT_SECS    (3),
    .NUM_LAPS      (2),
    .TIME_MAX      (999)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_pulse   (start_pulse),
    .pause_pulse   (pause_pulse),
    .lap_pulse     (lap_pulse),
    .state         (state),
    .countdown     (countdown),
    .lap_count     (lap_count),
    .race_time_sec (race_time_sec),
    .go_pulse      (go_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic l);
    start_pulse = s;
    pause_pulse = p;
    lap_pulse   = l;
    cyc();
    start_pulse = 1'b0;
    pause_pulse = 1'b0;
    lap_pulse   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0; lap_pulse = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    check("reset_state", 32'(state), 0);
    check("reset_countdown", 32'(countdown), 0);
    check("reset_lap", 32'(lap_count), 0);
    check("reset_time", 32'(race_time_sec), 0);
    check("reset_go", 32'(go_pulse), 0);

    // IDLE ignores pause/lap
    pulse(1'b0, 1'b1, 1'b1);
    check("idle_ignore", 32'(state), 0);
    pulse(1'b1, 1'b0, 1'b0);
    check("to_setting", 32'(state), 1);

    // Countdown timing (t = first COUNTDOWN cycle)
    pulse(1'b1, 1'b0, 1'b0);
    check("cd_state", 32'(state), 3);
    check("cd_t0", 32'(countdown), 3);
    pulse(1'b0, 1'b1, 1'b1);
    check("cd_ignore_lap", 32'(lap_count), 0);
    check("cd_ignore_pause", 32'(state), 3);
    cyc(3);
    check("cd_t4", 32'(countdown), 2);
    cyc(3);
    check("cd_t7", 32'(countdown), 2);
    cyc(1);
    check("cd_t8", 32'(countdown), 1);
    cyc(3);
    check("cd_t11_go", 32'(go_pulse), 0);
    cyc(1);
    check("t12_state", 32'(state), 4);
    check("t12_countdown", 32'(countdown), 0);
    check("t12_go", 32'(go_pulse), 1);
    cyc(1);
    check("t13_go", 32'(go_pulse), 0);

    // Race time: ticks land at t+15, t+19
    cyc(6);
    check("t19_time", 32'(race_time_sec), 1);
    cyc(1);
    check("t20_time", 32'(race_time_sec), 2);

    // Pause in cycle t+20; prescaler freezes at 1
    pulse(1'b0, 1'b1, 1'b0);
    check("pause_state", 32'(state), 5);
    cyc(10);
    pulse(1'b1, 1'b0, 1'b1);
    cyc(9);
    check("pause_time_hold", 32'(race_time_sec), 2);
    check("pause_lap_ignored", 32'(lap_count), 0);
    check("pause_start_ignored", 32'(state), 5);

    // Resume: prescaler restarts at 1, so tick after 3 cycles, not 4
    pulse(1'b0, 1'b1, 1'b0);
    check("resume_state", 32'(state), 4);
    cyc(2);
    check("resume_m3_time", 32'(race_time_sec), 2);
    cyc(1);
    check("resume_m4_time", 32'(race_time_sec), 3);

    // Laps
    pulse(1'b0, 1'b0, 1'b1);
    check("lap1_count", 32'(lap_count), 1);
    check("lap1_state", 32'(state), 4);
    pulse(1'b0, 1'b1, 1'b1);
    check("lap2_count", 32'(lap_count), 2);
    check("lap2_finish", 32'(state), 6);
    cyc(8);
    check("finish_time_hold", 32'(race_time_sec), 3);
    check("finish_lap_hold", 32'(lap_count), 2);
    pulse(1'b1, 1'b0, 1'b0);
    check("fin_to_idle", 32'(state), 0);
    check("fin_lap_clr", 32'(lap_count), 0);
    check("fin_time_clr", 32'(race_time_sec), 0);

    // Simultaneous lap+pause with race not complete
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    cyc(12);
    check("race2_state", 32'(state), 4);
    pulse(1'b0, 1'b1, 1'b1);
    check("lp_lap", 32'(lap_count), 1);
    check("lp_state", 32'(state), 5);

    // Async reset mid-COUNTDOWN
    pulse(1'b0, 1'b1, 1'b0);
    check("back_racing", 32'(state), 4);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    cyc(2);
    check("pre_rst_state", 32'(state), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_cd", 32'(countdown), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_state", 32'(state), 0);

    // Illegal state code recovers to IDLE
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    cyc(1);
    check("illegal_to_idle", 32'(state), 0);
    check("illegal_cd", 32'(countdown), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/race_state_fsm.md
Name: race_state_fsm

Overview:
Top-level game-flow controller for the racing game. It produces the 3-bit race state consumed by the physics engine and the display/HUD, sequences IDLE→SETTING→COUNTDOWN→RACING⇄PAUSE→FINISH, and runs the countdown seconds, race elapsed-time and lap counter. It sits directly upstream of the physics engine, on the same clock.

Parameters:
TICKS_PER_SEC, 100_000_000, clk cycles per one-second tick (≥2)
COUNT_SECS, 3, countdown length in seconds (1..15)
NUM_LAPS, 3, laps required to finish (1..15)
TIME_MAX, 999, saturation value of race_time_sec

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start_pulse  in  1  one-cycle debounced start/confirm button
pause_pulse  in  1  one-cycle debounced pause toggle
lap_pulse  in  1  one-cycle finish-line crossing from lap detector
state  out  3  race state code: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
countdown  out  4  seconds remaining; nonzero only in COUNTDOWN
lap_count  out  4  completed laps
race_time_sec  out  10  elapsed racing seconds, saturating
go_pulse  out  1  high exactly for the first cycle state==RACING after COUNTDOWN

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, countdown=0, lap_count=0, race_time_sec=0, go_pulse=0, prescaler=0.
- All outputs registered. A transition caused by an input pulse in cycle n is visible in cycle n+1.
- Prescaler 0..TICKS_PER_SEC-1. sec_tick is asserted when prescaler==TICKS_PER_SEC-1, then the prescaler wraps to 0.
  - Counts only in COUNTDOWN and RACING.
  - Frozen (value held) in PAUSE.
  - Forced to 0 in IDLE, SETTING and FINISH.
- IDLE: start_pulse → SETTING. Other inputs ignored.
- SETTING: start_pulse → COUNTDOWN; countdown loads COUNT_SECS, prescaler=0.
- COUNTDOWN:
  - sec_tick with countdown>1: countdown-1.
  - sec_tick with countdown==1: → RACING, countdown=0, go_pulse=1 for one cycle.
  - pause_pulse and lap_pulse ignored. Prescaler continues across the transition with no reset.
- RACING:
  - sec_tick: race_time_sec+1, saturating at TIME_MAX.
  - lap_pulse: lap_count+1. If the new value equals NUM_LAPS → FINISH.
  - pause_pulse: → PAUSE.
  - Simultaneous lap_pulse and pause_pulse: the lap is counted first. If it completes the race → FINISH, otherwise → PAUSE.
  - A sec_tick in the same cycle is still counted.
- PAUSE: pause_pulse → RACING. lap_pulse, start_pulse and sec_tick have no effect. All counters hold.
- FINISH: lap_count and race_time_sec hold for display. start_pulse → IDLE and clears lap_count, race_time_sec and countdown.
- start_pulse is ignored in COUNTDOWN, RACING and PAUSE; there is no abort path.
- Illegal state codes (2, 7) → IDLE next cycle, with counters cleared.
- Widths: lap_count saturates at 15. Prescaler width is $clog2(TICKS_PER_SEC).
- rst_n asserted mid-race returns to IDLE immediately, asynchronously. Release is synchronous to clk edges.

Decomposition:
- Shared package race_pkg holds the state code localparams (IDLE, SETTING, COUNTDOWN, RACING, PAUSE, FINISH). The physics engine and HUD use the same encoding.
- One sub-module, sec_tick_gen: the prescaler, with enable, freeze and clear inputs, emitting sec_tick.
- FSM and counters stay in race_state_fsm.

Test Plan:
(Bench parameters: TICKS_PER_SEC=4, COUNT_SECS=3, NUM_LAPS=2.)
- Reset then idle inputs → state=0, all counters 0. start_pulse at cycle n → state=1 at n+1.
- Second start_pulse entering COUNTDOWN at cycle t → countdown=3 at t, 2 at t+4, 1 at t+8; state=4, countdown=0 and go_pulse=1 at t+12; go_pulse=0 at t+13.
- In RACING for 8 cycles → race_time_sec=2. pause_pulse → state=5. Hold 20 cycles → race_time_sec still 2, lap_pulse ignored. pause_pulse → state=4, and the next tick occurs after the remaining prescaler count, not a full second.
- lap_pulse → lap_count=1, state stays 4. lap_pulse and pause_pulse in the same cycle → lap_count=2, state=6. Then start_pulse → state=0 with lap_count=0 and race_time_sec=0.
- lap_pulse and pause_pulse together when lap_count=0 → lap_count=1, state=5.
- rst_n low mid-COUNTDOWN, asynchronously between clock edges → state=0 and countdown=0 immediately. Forcing state to 7 → state=0 at the next edge.
